// File: rtl/muldiv_seq_if.sv
// Handshake and ALU-borrow signals between the core and the iterative mul/div sequencer.
// The core side is the master; the sequencer is the slave.
interface muldiv_seq_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     start;
  logic [1:0]               op;
  logic [DATA_WIDTH-1:0]    opa;
  logic [DATA_WIDTH-1:0]    opb;
  logic                     busy;
  logic                     done;
  logic [DATA_WIDTH-1:0]    result;
  logic                     alu_own;
  logic [DATA_WIDTH-1:0]    alu_srca;
  logic [DATA_WIDTH-1:0]    alu_srcb;
  logic [OPCODE_LENGTH-1:0] alu_op;
  logic [DATA_WIDTH-1:0]    alu_result;

  modport master (
    output start, op, opa, opb, alu_result,
    input  busy, done, result, alu_own, alu_srca, alu_srcb, alu_op
  );

  modport slave (
    input  start, op, opa, opb, alu_result,
    output busy, done, result, alu_own, alu_srca, alu_srcb, alu_op
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU that borrows the shared ALU for one
// add or subtract per iteration, 32 iterations per operation.
module muldiv_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = OPCODE_LENGTH'(4'b0010);

  logic [1:0]            state_reg;
  logic [DATA_WIDTH-1:0] hi_reg, lo_reg, div_reg, result_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [1:0]            op_q_reg;

  logic [DATA_WIDTH-1:0] hi_next, lo_next;
  logic [DATA_WIDTH-1:0] rem_shift, sum;
  logic                  ob, ge, carry;

  always_comb begin
    // Divide: shift the partial remainder left; ob is the bit shifted out of hi,
    // which guarantees the subtraction succeeds even when r < div numerically.
    rem_shift = {hi_reg[DATA_WIDTH-2:0], lo_reg[DATA_WIDTH-1]};
    ob        = hi_reg[DATA_WIDTH-1];
    ge        = ob | (rem_shift >= div_reg);
    // Multiply: carry out of the ALU add is recovered by an unsigned wrap compare.
    sum       = lo_reg[0] ? bus.alu_result : hi_reg;
    carry     = lo_reg[0] & (bus.alu_result < hi_reg);

    if (op_q_reg[1]) begin
      hi_next = ge ? bus.alu_result : rem_shift;
      lo_next = {lo_reg[DATA_WIDTH-2:0], ge};
    end else begin
      hi_next = {carry, sum[DATA_WIDTH-1:1]};
      lo_next = {sum[0], lo_reg[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    bus.busy     = (state_reg == RUN) || (state_reg == DONE);
    bus.done     = (state_reg == DONE);
    bus.result   = result_reg;
    bus.alu_own  = (state_reg == RUN);
    bus.alu_srca = '0;
    bus.alu_srcb = '0;
    bus.alu_op   = ALU_ADD;
    if (state_reg == RUN) begin
      bus.alu_srca = op_q_reg[1] ? rem_shift : hi_reg;
      bus.alu_srcb = div_reg;
      bus.alu_op   = op_q_reg[1] ? ALU_SUB : ALU_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      hi_reg     <= '0;
      lo_reg     <= '0;
      div_reg    <= '0;
      cnt_reg    <= '0;
      op_q_reg   <= 2'b00;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            op_q_reg <= bus.op;
            div_reg  <= bus.opb;
            lo_reg   <= bus.opa;
            hi_reg   <= '0;
            cnt_reg  <= '0;
            if (bus.op[1] && (bus.opb == '0)) begin
              result_reg <= bus.op[0] ? bus.opa : '1;
              state_reg  <= DONE;
            end else begin
              state_reg  <= RUN;
            end
          end
        end
        RUN: begin
          hi_reg  <= hi_next;
          lo_reg  <= lo_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
            // MULHU and REMU take the high word; MUL and DIVU the low word.
            result_reg <= op_q_reg[0] ? hi_next : lo_next;
            state_reg  <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: a combinational ALU model answers the
// sequencer, and expected results travel through a scoreboard queue.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] sb[$];

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU: SUB for 0010, ADD otherwise.
  assign bus.alu_result = (bus.alu_op == 4'b0010) ? (bus.alu_srca - bus.alu_srcb)
                                                  : (bus.alu_srca + bus.alu_srcb);

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, input bit immediate, input string name);
    logic [31:0] exp_res;
    logic [3:0]  exp_aluop;
    int          lat, own, exp_lat, exp_own;
    bit          opbad;
    bit          div0;
    div0      = o[1] && (b == 32'd0);
    exp_lat   = div0 ? 0 : 32;
    exp_own   = div0 ? 0 : 32;
    exp_aluop = o[1] ? 4'b0010 : 4'b0100;
    sb.push_back(model(o, a, b));
    if (!immediate) @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.opa = a; bus.opb = b;
    @(negedge clk);
    // Scramble the inputs after acceptance; the latched copies must be used.
    bus.start = 1'b0; bus.op = ~o; bus.opa = $urandom; bus.opb = $urandom;
    lat = 0; own = 0; opbad = 1'b0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.alu_own === 1'b1) begin
        own++;
        if (bus.alu_op !== exp_aluop) opbad = 1'b1;
      end
      if (inject && lat == 5) begin
        bus.start = 1'b1; bus.op = 2'b00; bus.opa = 32'd11; bus.opb = 32'd13;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    exp_res = sb.pop_front();
    $display("%s op=%0d a=%h b=%h result=%h expect=%h latency=%0d own=%0d",
             name, o, a, b, bus.result, exp_res, lat, own);
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (bus.result !== exp_res) begin
      errors++; $display("FAIL %s result: got %h want %h", name, bus.result, exp_res);
    end
    checks++;
    if (own !== exp_own) begin
      errors++; $display("FAIL %s alu_own cycles: got %0d want %0d", name, own, exp_own);
    end
    checks++;
    if (opbad) begin
      errors++; $display("FAIL %s alu_op during RUN: got wrong code want %b", name, exp_aluop);
    end
    if (inject) begin
      bus.start = 1'b1; bus.op = 2'b01; bus.opa = 32'hDEAD_BEEF; bus.opb = 32'd3;
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s return to idle: got done=%b busy=%b want 0 0", name, bus.done, bus.busy);
    end
    if (inject) begin
      repeat (3) @(negedge clk);
      checks++;
      if (bus.result !== exp_res || bus.busy !== 1'b0) begin
        errors++; $display("FAIL %s result hold: got %h busy=%b want %h busy=0", name, bus.result, bus.busy, exp_res);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1; bus.op = 2'b00; bus.opa = 32'd5; bus.opb = 32'd5;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.alu_own !== 1'b0 || bus.result !== 32'd0 ||
        bus.alu_srca !== 32'd0 || bus.alu_srcb !== 32'd0 || bus.alu_op !== 4'b0100) begin
      errors++;
      $display("FAIL reset outputs: got busy=%b done=%b own=%b result=%h srca=%h srcb=%h op=%b want 0 0 0 0 0 0 0100",
               bus.busy, bus.done, bus.alu_own, bus.result, bus.alu_srca, bus.alu_srcb, bus.alu_op);
    end
    reset = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset start ignored: got busy=%b want 0", bus.busy);
    end
    $display("reset done busy=%b result=%h", bus.busy, bus.result);
  endtask

  task automatic test_mul();
    run_op(2'b00, 32'd7, 32'd6, 1'b0, 1'b0, "mul_7x6");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "mulhu_max");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "mul_max");
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, "mulhu_mix");
  endtask

  task automatic test_div();
    run_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, "remu_100_7");
    run_op(2'b10, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "divu_max_1");
    run_op(2'b11, 32'hF000_0001, 32'h8000_0003, 1'b0, 1'b0, "remu_big");
  endtask

  task automatic test_divzero();
    run_op(2'b10, 32'd123, 32'd0, 1'b0, 1'b0, "divu_by0");
    run_op(2'b11, 32'd123, 32'd0, 1'b0, 1'b0, "remu_by0");
  endtask

  task automatic test_abort();
    bit saw_done;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.opa = 32'h1234_5678; bus.opb = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.alu_own !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
      errors++;
      $display("FAIL abort idle: got busy=%b own=%b done=%b result=%h want 0 0 0 0",
               bus.busy, bus.alu_own, bus.done, bus.result);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL abort no done: got a done pulse want none");
    end
    $display("abort reset applied mid-run");
    run_op(2'b00, 32'd3, 32'd5, 1'b0, 1'b0, "mul_after_abort");
  endtask

  task automatic test_ignore_start();
    run_op(2'b00, 32'd7, 32'd6, 1'b1, 1'b0, "mul_ignore");
    run_op(2'b10, 32'd1000, 32'd33, 1'b1, 1'b0, "divu_ignore");
  endtask

  task automatic test_back_to_back();
    run_op(2'b11, 32'd77, 32'd10, 1'b0, 1'b0, "b2b_first");
    run_op(2'b00, 32'd12, 32'd12, 1'b0, 1'b1, "b2b_second");
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.opa = 32'd0; bus.opb = 32'd0;
    test_reset();
    test_mul();
    test_div();
    test_divzero();
    test_abort();
    test_ignore_start();
    test_back_to_back();
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL scoreboard drain: got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
